as1802_io_cpld: RTL and testbench

- Memory- and I/O-mapped peripheral controller for an AS1802 (CDP1802-compatible) system.
- Decodes CPU bus strobes and drives the shared 8-bit data bus on reads.
- Provides an LED, two 8-bit output ports, an 8N1 UART, a mode-0 SPI master, EF flag lines and an interrupt request.
- Sits beside the CPU and answers the upper 32 KiB of address space (A15=1), plus the 1802 OUT/INP port numbers N=1..7.

---
 rtl/as1802_io_cpld.sv | 298 +++++++++++++++++++++++++++++
 tb/tb_as1802_io_cpld.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/as1802_io_cpld.sv
// AS1802 bus-side peripheral controller: LED, two output ports, 8N1 UART, mode-0 SPI master,
// EF flags and interrupt, reachable by memory cycles (A15=1) or OUT/INP port numbers.
module as1802_io_cpld #(
  parameter logic [7:0] RST_BAUD = 8'd103
) (
  input  logic       xclk,
  input  logic       rst_n,
  input  logic [3:0] addr,
  input  logic       A15,
  input  logic [2:0] N,
  input  logic       MRD_b,
  input  logic       MWR_b,
  inout  wire  [7:0] D,
  output logic       int_b,
  output logic [3:0] EF_b,
  output logic       LED,
  output logic [7:0] PORTA,
  output logic [7:0] PORTB,
  output logic       TXD,
  input  logic       RXD,
  output logic       SCK,
  output logic       SDO,
  input  logic       SDI
);

  // ---------------------------------------------------------------------------
  // Bus decode
  // ---------------------------------------------------------------------------
  logic       mem_sel, io_sel, rd_cond, wr_cond;
  logic       wr_q, rd_q, wr_pulse, rd_end;
  logic [3:0] idx, rd_idx_q;
  logic [7:0] rd_data;

  assign mem_sel  = (N == 3'd0) && A15;
  assign io_sel   = (N != 3'd0);
  assign idx      = io_sel ? {1'b0, N} : addr;
  // An OUT cycle reads memory onto D, so MRD_b low doubles as our write strobe.
  assign rd_cond  = (mem_sel && !MRD_b) || (io_sel && MRD_b);
  assign wr_cond  = (mem_sel && !MWR_b) || (io_sel && !MRD_b);
  assign wr_pulse = wr_cond && !wr_q;
  assign rd_end   = rd_q && !rd_cond;

  always_ff @(posedge xclk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q     <= 1'b0;
      rd_q     <= 1'b0;
      rd_idx_q <= 4'd0;
    end else begin
      wr_q <= wr_cond;
      rd_q <= rd_cond;
      if (rd_cond) rd_idx_q <= idx;
    end
  end

  // ---------------------------------------------------------------------------
  // Configuration registers
  // ---------------------------------------------------------------------------
  logic [7:0] divisor;
  logic [3:0] spi_div;
  logic [2:0] ie;

  always_ff @(posedge xclk or negedge rst_n) begin
    if (!rst_n) begin
      LED     <= 1'b0;
      PORTA   <= 8'h00;
      PORTB   <= 8'h00;
      divisor <= RST_BAUD;
      spi_div <= 4'd0;
      ie      <= 3'd0;
    end else if (wr_pulse) begin
      case (idx)
        4'd0: LED     <= D[0];
        4'd1: PORTA   <= D;
        4'd2: PORTB   <= D;
        4'd5: divisor <= D;
        4'd7: spi_div <= D[3:0];
        4'd8: ie      <= D[2:0];
        default: ;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // UART transmitter
  // ---------------------------------------------------------------------------
  logic       tx_busy, tx_start;
  logic [9:0] tx_shift;
  logic [7:0] tx_cnt;
  logic [3:0] tx_bit;

  assign tx_start = wr_pulse && (idx == 4'd3) && !tx_busy;

  always_ff @(posedge xclk or negedge rst_n) begin
    if (!rst_n) begin
      tx_busy  <= 1'b0;
      tx_shift <= 10'h3ff;
      tx_cnt   <= 8'd0;
      tx_bit   <= 4'd0;
    end else if (tx_start) begin
      tx_busy  <= 1'b1;
      tx_shift <= {1'b1, D, 1'b0};
      tx_cnt   <= 8'd0;
      tx_bit   <= 4'd0;
    end else if (tx_busy) begin
      if (tx_cnt == divisor) begin
        tx_cnt <= 8'd0;
        if (tx_bit == 4'd9) begin
          tx_busy <= 1'b0;
        end else begin
          tx_shift <= {1'b1, tx_shift[9:1]};
          tx_bit   <= tx_bit + 4'd1;
        end
      end else begin
        tx_cnt <= tx_cnt + 8'd1;
      end
    end
  end

  assign TXD = tx_busy ? tx_shift[0] : 1'b1;

  // ---------------------------------------------------------------------------
  // UART receiver
  // ---------------------------------------------------------------------------
  typedef enum logic [1:0] {RxIdle, RxStart, RxData, RxStop} rx_state_e;

  rx_state_e  rx_st_q, rx_st_d;
  logic [7:0] rx_cnt_q, rx_cnt_d, rx_sh_q, rx_sh_d, rx_data;
  logic [2:0] rx_bit_q, rx_bit_d;
  logic       rx_s1, rx_s2, rx_prev, rx_valid, rx_ready, rx_overrun, rx_clr;

  always_comb begin
    rx_st_d  = rx_st_q;
    rx_cnt_d = rx_cnt_q;
    rx_bit_d = rx_bit_q;
    rx_sh_d  = rx_sh_q;
    rx_valid = 1'b0;
    case (rx_st_q)
      RxIdle: begin
        if (rx_prev && !rx_s2) begin
          rx_st_d  = RxStart;
          rx_cnt_d = 8'd0;
        end
      end
      RxStart: begin
        // Half a bit in: the start bit must still be low, otherwise it was a glitch.
        if (rx_cnt_q == {1'b0, divisor[7:1]}) begin
          rx_cnt_d = 8'd0;
          rx_bit_d = 3'd0;
          rx_st_d  = rx_s2 ? RxIdle : RxData;
        end else begin
          rx_cnt_d = rx_cnt_q + 8'd1;
        end
      end
      RxData: begin
        if (rx_cnt_q == divisor) begin
          rx_cnt_d = 8'd0;
          rx_sh_d  = {rx_s2, rx_sh_q[7:1]};
          rx_bit_d = rx_bit_q + 3'd1;
          if (rx_bit_q == 3'd7) rx_st_d = RxStop;
        end else begin
          rx_cnt_d = rx_cnt_q + 8'd1;
        end
      end
      RxStop: begin
        if (rx_cnt_q == divisor) begin
          rx_st_d  = RxIdle;
          rx_valid = rx_s2;
        end else begin
          rx_cnt_d = rx_cnt_q + 8'd1;
        end
      end
      default: rx_st_d = RxIdle;
    endcase
  end

  assign rx_clr = rd_end && (rd_idx_q == 4'd3);

  always_ff @(posedge xclk or negedge rst_n) begin
    if (!rst_n) begin
      rx_s1      <= 1'b1;
      rx_s2      <= 1'b1;
      rx_prev    <= 1'b1;
      rx_st_q    <= RxIdle;
      rx_cnt_q   <= 8'd0;
      rx_bit_q   <= 3'd0;
      rx_sh_q    <= 8'h00;
      rx_data    <= 8'h00;
      rx_ready   <= 1'b0;
      rx_overrun <= 1'b0;
    end else begin
      rx_s1    <= RXD;
      rx_s2    <= rx_s1;
      rx_prev  <= rx_s2;
      rx_st_q  <= rx_st_d;
      rx_cnt_q <= rx_cnt_d;
      rx_bit_q <= rx_bit_d;
      rx_sh_q  <= rx_sh_d;
      if (rx_clr) begin
        rx_ready   <= 1'b0;
        rx_overrun <= 1'b0;
      end
      // Placed after the clear so a simultaneous arrival wins.
      if (rx_valid) begin
        rx_data  <= rx_sh_q;
        rx_ready <= 1'b1;
        if (rx_ready && !rx_clr) rx_overrun <= 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // SPI master, mode 0, MSB first
  // ---------------------------------------------------------------------------
  logic       spi_busy, spi_done, spi_start, spi_clr;
  logic [7:0] spi_tx, spi_rx, spi_rdata;
  logic [3:0] spi_cnt;
  logic [2:0] spi_bit;

  assign spi_start = wr_pulse && (idx == 4'd6) && !spi_busy;
  assign spi_clr   = rd_end && (rd_idx_q == 4'd6);

  always_ff @(posedge xclk or negedge rst_n) begin
    if (!rst_n) begin
      spi_busy  <= 1'b0;
      spi_done  <= 1'b0;
      spi_tx    <= 8'h00;
      spi_rx    <= 8'h00;
      spi_rdata <= 8'h00;
      spi_cnt   <= 4'd0;
      spi_bit   <= 3'd0;
      SCK       <= 1'b0;
      SDO       <= 1'b0;
    end else begin
      if (spi_clr) spi_done <= 1'b0;
      if (spi_start) begin
        spi_busy <= 1'b1;
        spi_tx   <= D;
        SDO      <= D[7];
        SCK      <= 1'b0;
        spi_cnt  <= 4'd0;
        spi_bit  <= 3'd0;
      end else if (spi_busy) begin
        if (spi_cnt == spi_div) begin
          spi_cnt <= 4'd0;
          if (!SCK) begin
            SCK    <= 1'b1;
            spi_rx <= {spi_rx[6:0], SDI};
          end else begin
            SCK <= 1'b0;
            if (spi_bit == 3'd7) begin
              spi_busy  <= 1'b0;
              spi_done  <= 1'b1;
              spi_rdata <= spi_rx;
            end else begin
              spi_bit <= spi_bit + 3'd1;
              spi_tx  <= {spi_tx[6:0], 1'b0};
              SDO     <= spi_tx[6];
            end
          end
        end else begin
          spi_cnt <= spi_cnt + 4'd1;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Flags, interrupt and read-back
  // ---------------------------------------------------------------------------
  logic int_pending;

  assign int_pending = (ie[0] && rx_ready) || (ie[1] && !tx_busy) || (ie[2] && spi_done);
  assign EF_b        = ~{int_pending, spi_busy, tx_busy, rx_ready};

  always_ff @(posedge xclk or negedge rst_n) begin
    if (!rst_n) int_b <= 1'b1;
    else        int_b <= ~int_pending;
  end

  always_comb begin
    rd_data = 8'h00;
    case (idx)
      4'd0: rd_data = {7'b0, LED};
      4'd1: rd_data = PORTA;
      4'd2: rd_data = PORTB;
      4'd3: rd_data = rx_data;
      4'd4: rd_data = {5'b0, rx_overrun, tx_busy, rx_ready};
      4'd5: rd_data = divisor;
      4'd6: rd_data = spi_rdata;
      4'd7: rd_data = {spi_busy, spi_done, 2'b0, spi_div};
      4'd8: rd_data = {5'b0, ie};
      default: rd_data = 8'h00;
    endcase
  end

  assign D = rd_cond ? rd_data : 8'bz;

endmodule

// File: tb/tb_as1802_io_cpld.sv
// Directed bench for as1802_io_cpld: bus decode, ports, UART TX/RX, SPI and interrupt.
module tb_as1802_io_cpld;

  logic       xclk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] addr = 4'd0;
  logic       A15 = 1'b0;
  logic [2:0] N = 3'd0;
  logic       MRD_b = 1'b1;
  logic       MWR_b = 1'b1;
  wire  [7:0] D;
  logic [7:0] d_drv = 8'h00;
  logic       d_oe = 1'b0;
  logic       RXD = 1'b1;
  logic       SDI = 1'b0;
  logic       int_b, LED, TXD, SCK, SDO;
  logic [3:0] EF_b;
  logic [7:0] PORTA, PORTB;

  int n_checks = 0;
  int n_pass = 0;

  // Undriven bus floats high through the pull-ups, so "high-Z" reads as FF.
  assign D = d_oe ? d_drv : 8'bz;
  for (genvar gi = 0; gi < 8; gi++) begin : g_pu
    pullup (D[gi]);
  end

  as1802_io_cpld #(.RST_BAUD(8'd103)) dut (
    .xclk(xclk), .rst_n(rst_n), .addr(addr), .A15(A15), .N(N), .MRD_b(MRD_b), .MWR_b(MWR_b),
    .D(D), .int_b(int_b), .EF_b(EF_b), .LED(LED), .PORTA(PORTA), .PORTB(PORTB), .TXD(TXD),
    .RXD(RXD), .SCK(SCK), .SDO(SDO), .SDI(SDI)
  );

  always #5 xclk = ~xclk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  task automatic mem_write(input logic [3:0] a, input logic [7:0] v, input int hold,
                           input logic [7:0] v2);
    @(negedge xclk);
    A15 = 1'b1; addr = a; d_drv = v; d_oe = 1'b1; MWR_b = 1'b0;
    @(negedge xclk);
    d_drv = v2;
    repeat (hold - 1) @(negedge xclk);
    MWR_b = 1'b1; d_oe = 1'b0; A15 = 1'b0;
  endtask

  task automatic cyc_read(input logic a15_v, input logic [2:0] n_v, input logic [3:0] a,
                          output logic [7:0] v);
    @(negedge xclk);
    A15 = a15_v; N = n_v; addr = a; MRD_b = (n_v == 3'd0) ? 1'b0 : 1'b1;
    @(negedge xclk);
    v = D;
    N = 3'd0; MRD_b = 1'b1; A15 = 1'b0;
    @(negedge xclk);
  endtask

  task automatic mem_read(input logic [3:0] a, output logic [7:0] v);
    cyc_read(1'b1, 3'd0, a, v);
  endtask

  task automatic io_out(input logic [2:0] n_v, input logic [7:0] v);
    @(negedge xclk);
    N = n_v; MRD_b = 1'b0; d_drv = v; d_oe = 1'b1;
    @(negedge xclk);
    N = 3'd0; MRD_b = 1'b1; d_oe = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    logic [9:0] fr;
    fr = {1'b1, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      RXD = fr[i];
      repeat (4) @(negedge xclk);
    end
    repeat (4) @(negedge xclk);
  endtask

  logic [7:0] rv;
  logic [9:0] tx_exp;
  logic [7:0] sdo_byte;
  logic       sck_prev, done_seen;
  int         pulses, high_cycles;

  initial begin
    repeat (3) @(negedge xclk);
    rst_n = 1'b1;
    @(negedge xclk);

    check("idle_d", D, 8'hff);
    check("rst_txd", TXD, 1'b1);
    check("rst_int_b", int_b, 1'b1);
    check("rst_ef_b", EF_b, 4'hf);
    check("rst_porta", PORTA, 8'h00);
    check("rst_portb", PORTB, 8'h00);
    check("rst_led", LED, 1'b0);
    check("rst_sck", SCK, 1'b0);
    check("rst_sdo", SDO, 1'b0);
    mem_read(4'd5, rv); check("rst_baud", rv, 8'd103);
    mem_read(4'd0, rv); check("rd_led0", rv, 8'h00);

    // Data changes after the first edge; only the first value must commit.
    mem_write(4'd1, 8'ha5, 3, 8'h11);
    check("porta_once", PORTA, 8'ha5);
    mem_write(4'd0, 8'h01, 1, 8'h00);
    check("led_set", LED, 1'b1);
    mem_read(4'd0, rv); check("rd_led1", rv, 8'h01);

    io_out(3'd2, 8'h3c);
    check("out_portb", PORTB, 8'h3c);
    cyc_read(1'b0, 3'd2, 4'd0, rv); check("inp_portb", rv, 8'h3c);
    cyc_read(1'b0, 3'd0, 4'd1, rv); check("a15_low_z", rv, 8'hff);
    mem_write(4'd9, 8'hff, 1, 8'h00);
    mem_read(4'd9, rv); check("rd_reg9", rv, 8'h00);
    mem_read(4'd4, rv); check("status_idle", rv, 8'h00);

    // UART TX at 4 clocks/bit, ie1 armed.
    mem_write(4'd5, 8'h03, 1, 8'h00);
    mem_read(4'd5, rv); check("rd_div", rv, 8'h03);
    mem_write(4'd8, 8'h02, 1, 8'h00);
    @(negedge xclk);
    check("int_txidle", int_b, 1'b0);
    mem_write(4'd3, 8'h55, 1, 8'h00);
    @(negedge xclk);
    tx_exp = 10'b1010101010;
    for (int i = 0; i < 10; i++) begin
      check($sformatf("txd_bit%0d", i), TXD, tx_exp[i]);
      if (i == 5) begin
        check("ef1_busy", EF_b[1], 1'b0);
        check("int_txbusy", int_b, 1'b1);
      end
      repeat (4) @(negedge xclk);
    end
    @(negedge xclk);
    check("ef1_done", EF_b[1], 1'b1);
    check("int_txdone", int_b, 1'b0);
    check("txd_idle", TXD, 1'b1);
    mem_write(4'd8, 8'h00, 1, 8'h00);

    // UART RX
    send_byte(8'hc3);
    check("ef_rxready", EF_b, 4'he);
    mem_read(4'd4, rv); check("status_rx", rv, 8'h01);
    mem_read(4'd3, rv); check("rx_c3", rv, 8'hc3);
    mem_read(4'd4, rv); check("status_clr", rv, 8'h00);
    send_byte(8'h5a);
    send_byte(8'ha5);
    mem_read(4'd4, rv); check("status_ovr", rv, 8'h05);
    mem_read(4'd3, rv); check("rx_a5", rv, 8'ha5);
    mem_read(4'd4, rv); check("status_ovr_clr", rv, 8'h00);

    // SPI, spi_div=0, SDI high
    SDI = 1'b1;
    mem_write(4'd6, 8'h81, 1, 8'h00);
    sck_prev = 1'b0; done_seen = 1'b0; pulses = 0; high_cycles = 0; sdo_byte = 8'h00;
    for (int c = 0; c < 200 && !done_seen; c++) begin
      @(negedge xclk);
      if (SCK && !sck_prev) begin
        sdo_byte = {sdo_byte[6:0], SDO};
        pulses++;
      end
      if (SCK) high_cycles++;
      sck_prev = SCK;
      if (EF_b[2]) done_seen = 1'b1;
    end
    check("spi_finished", done_seen, 1'b1);
    check("spi_pulses", pulses[15:0], 16'd8);
    check("spi_high_len", high_cycles[15:0], 16'd8);
    check("spi_sdo", sdo_byte, 8'h81);
    check("spi_sck_idle", SCK, 1'b0);
    mem_read(4'd7, rv); check("spi_stat_done", rv, 8'h40);
    mem_read(4'd6, rv); check("spi_rx", rv, 8'hff);
    mem_read(4'd7, rv); check("spi_stat_clr", rv, 8'h00);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
